core_array_gbus_fabric: RTL and testbench

//  Parametrised global-bus fabric between the array controller and the HNUM x VNUM core grid.
//  Per row: one valid/ready request channel. Writes may be multicast to several columns; reads must target exactly one.

---
 rtl/array_pkg.sv | 23 ++
 rtl/gbus_rsp_fifo.sv | 56 +++++
 rtl/core_array_gbus_fabric.sv | 177 +++++++++++++++++
 tb/tb_core_array_gbus_fabric.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/array_pkg.sv
// Shared constants and helpers for the core-array global-bus fabric.
package array_pkg;

  localparam int unsigned ERR_W       = 3;
  localparam int unsigned ERR_BADMASK = 0;
  localparam int unsigned ERR_MULTI   = 1;
  localparam int unsigned ERR_UNEXP   = 2;

  // Column masks are assumed to fit in 32 bits (VNUM <= 32).
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

  function automatic logic is_onehot(input logic [31:0] v);
    return popcount(v) == 1;
  endfunction

endpackage

// File: rtl/gbus_rsp_fifo.sv
// Per-row response FIFO; storage is flops so the head entry is driven straight from registers.
module gbus_rsp_fifo #(
  parameter int unsigned Width = 66,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] rdata_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Depth-1:0][Width-1:0] mem_q, mem_d;
  logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]               cnt_q, cnt_d;
  logic                        do_push, do_pop;

  always_comb begin
    do_pop   = pop_i & (cnt_q != '0);
    // A push into a full FIFO is only legal alongside a pop.
    do_push  = push_i & ((cnt_q != (PtrW+1)'(Depth)) | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    cnt_d = cnt_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign valid_o = (cnt_q != '0);
  assign rdata_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/core_array_gbus_fabric.sv
// Global-bus fabric between the array controller and the HNUM x VNUM core grid:
// per-row request pipe, credit-controlled read return FIFO, error flags and acc_num skew chain.
module core_array_gbus_fabric
  import array_pkg::*;
#(
  parameter int unsigned HNUM      = 4,
  parameter int unsigned VNUM      = 4,
  parameter int unsigned GBUS_DATA = 64,
  parameter int unsigned GBUS_ADDR = 12,
  parameter int unsigned CDATA_BIT = 8,
  parameter int unsigned REQ_PIPE  = 1,
  parameter int unsigned RSP_DEPTH = 4,
  parameter int unsigned SKEW      = 1,
  localparam int unsigned ColW     = (VNUM > 1) ? $clog2(VNUM) : 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [HNUM*CDATA_BIT-1:0]      cfg_acc_num,
  output logic [HNUM*VNUM*CDATA_BIT-1:0] core_acc_num,
  input  logic [HNUM-1:0]                req_valid,
  output logic [HNUM-1:0]                req_ready,
  input  logic [HNUM-1:0]                req_wr,
  input  logic [HNUM*VNUM-1:0]           req_col_mask,
  input  logic [HNUM*GBUS_ADDR-1:0]      req_addr,
  input  logic [HNUM*GBUS_DATA-1:0]      req_wdata,
  output logic [HNUM*VNUM-1:0]           core_gbus_wen,
  output logic [HNUM*VNUM-1:0]           core_gbus_ren,
  output logic [HNUM*GBUS_ADDR-1:0]      core_gbus_addr,
  output logic [HNUM*GBUS_DATA-1:0]      core_gbus_wdata,
  input  logic [HNUM*VNUM-1:0]           core_rvalid,
  input  logic [HNUM*VNUM*GBUS_DATA-1:0] core_rdata,
  output logic [HNUM-1:0]                rsp_valid,
  input  logic [HNUM-1:0]                rsp_ready,
  output logic [HNUM*GBUS_DATA-1:0]      rsp_data,
  output logic [HNUM*ColW-1:0]           rsp_col,
  output logic [HNUM*ERR_W-1:0]          err_sticky,
  input  logic [HNUM-1:0]                err_clr
);

  localparam int unsigned CW  = $clog2(RSP_DEPTH + 1);
  localparam int unsigned SkN = VNUM * SKEW;
  localparam int unsigned FW  = GBUS_DATA + ColW;

  for (genvar g = 0; g < HNUM; g++) begin : g_row
    logic [VNUM-1:0]      mask, rv;
    logic                 acc, rd_legal, push, pop, fifo_valid;
    logic [ColW-1:0]      ret_col;
    logic [GBUS_DATA-1:0] ret_data;
    logic [FW-1:0]        fifo_rdata;

    logic [REQ_PIPE-1:0]                vld_q, vld_d;
    logic [REQ_PIPE-1:0][VNUM-1:0]      wen_q, wen_d, ren_q, ren_d;
    logic [REQ_PIPE-1:0][GBUS_ADDR-1:0] addr_q, addr_d;
    logic [REQ_PIPE-1:0][GBUS_DATA-1:0] wdata_q, wdata_d;

    logic [CW-1:0]    cred_q, cred_d, out_q, out_d;
    logic             ready_q, ready_d;
    logic [ERR_W-1:0] err_q, err_d, err_set;

    logic [SkN-1:0][CDATA_BIT-1:0] sk_q, sk_d;

    // Request path: stage 0 captures the accepted request, later stages shift.
    always_comb begin
      mask     = req_col_mask[g*VNUM +: VNUM];
      acc      = req_valid[g] & ready_q;
      rd_legal = acc & ~req_wr[g] & is_onehot(32'(mask));
      vld_d    = vld_q;
      wen_d    = wen_q;
      ren_d    = ren_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      vld_d[0] = acc;
      wen_d[0] = (acc & req_wr[g]) ? mask : '0;
      ren_d[0] = rd_legal ? mask : '0;
      if (acc) begin
        addr_d[0]  = req_addr[g*GBUS_ADDR +: GBUS_ADDR];
        wdata_d[0] = req_wdata[g*GBUS_DATA +: GBUS_DATA];
      end
      for (int k = 1; k < REQ_PIPE; k++) begin
        vld_d[k] = vld_q[k-1];
        wen_d[k] = wen_q[k-1];
        ren_d[k] = ren_q[k-1];
        if (vld_q[k-1]) begin
          addr_d[k]  = addr_q[k-1];
          wdata_d[k] = wdata_q[k-1];
        end
      end
    end

    // Return path, credits and sticky errors.
    always_comb begin
      rv       = core_rvalid[g*VNUM +: VNUM];
      ret_col  = '0;
      ret_data = '0;
      // Descending scan so the lowest active column wins.
      for (int j = VNUM - 1; j >= 0; j--) begin
        if (rv[j]) begin
          ret_col  = ColW'(j);
          ret_data = core_rdata[(g*VNUM + j)*GBUS_DATA +: GBUS_DATA];
        end
      end
      push    = (|rv) & (out_q != '0);
      pop     = fifo_valid & rsp_ready[g];
      out_d   = out_q + CW'(rd_legal) - CW'(push);
      cred_d  = cred_q + CW'(rd_legal) - CW'(pop);
      ready_d = (cred_d < CW'(RSP_DEPTH));

      err_set              = '0;
      err_set[ERR_BADMASK] = acc & ~req_wr[g] & ~is_onehot(32'(mask));
      err_set[ERR_MULTI]   = (popcount(32'(rv)) > 1);
      err_set[ERR_UNEXP]   = (|rv) & (out_q == '0);
      err_d                = (err_q & ~{ERR_W{err_clr[g]}}) | err_set;
    end

    always_comb begin
      sk_d    = sk_q;
      sk_d[0] = cfg_acc_num[g*CDATA_BIT +: CDATA_BIT];
      for (int k = 1; k < SkN; k++) begin
        sk_d[k] = sk_q[k-1];
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        vld_q   <= '0;
        wen_q   <= '0;
        ren_q   <= '0;
        addr_q  <= '0;
        wdata_q <= '0;
        cred_q  <= '0;
        out_q   <= '0;
        ready_q <= 1'b0;
        err_q   <= '0;
        sk_q    <= '0;
      end else begin
        vld_q   <= vld_d;
        wen_q   <= wen_d;
        ren_q   <= ren_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        cred_q  <= cred_d;
        out_q   <= out_d;
        ready_q <= ready_d;
        err_q   <= err_d;
        sk_q    <= sk_d;
      end
    end

    gbus_rsp_fifo #(
      .Width (FW),
      .Depth (RSP_DEPTH)
    ) u_rsp_fifo (
      .clk_i   (clk),
      .rst_ni  (rstn),
      .push_i  (push),
      .wdata_i ({ret_data, ret_col}),
      .pop_i   (pop),
      .valid_o (fifo_valid),
      .rdata_o (fifo_rdata)
    );

    assign req_ready[g]                            = ready_q;
    assign core_gbus_wen[g*VNUM +: VNUM]           = wen_q[REQ_PIPE-1];
    assign core_gbus_ren[g*VNUM +: VNUM]           = ren_q[REQ_PIPE-1];
    assign core_gbus_addr[g*GBUS_ADDR +: GBUS_ADDR] = addr_q[REQ_PIPE-1];
    assign core_gbus_wdata[g*GBUS_DATA +: GBUS_DATA] = wdata_q[REQ_PIPE-1];
    assign rsp_valid[g]                            = fifo_valid;
    assign rsp_data[g*GBUS_DATA +: GBUS_DATA]      = fifo_rdata[ColW +: GBUS_DATA];
    assign rsp_col[g*ColW +: ColW]                 = fifo_rdata[ColW-1:0];
    assign err_sticky[g*ERR_W +: ERR_W]            = err_q;

    for (genvar j = 0; j < VNUM; j++) begin : g_col
      assign core_acc_num[(g*VNUM + j)*CDATA_BIT +: CDATA_BIT] = sk_q[(j+1)*SKEW - 1];
    end
  end

endmodule

// File: tb/tb_core_array_gbus_fabric.sv
// Directed bench for core_array_gbus_fabric: vector table plus multi-cycle sequences.
module tb_core_array_gbus_fabric;

  localparam int HN = 4, VN = 4, GD = 64, GA = 12, CB = 8, CWB = 2;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic [HN*CB-1:0]       cfg_acc_num = '0;
  logic [HN*VN*CB-1:0]    core_acc_num;
  logic [HN-1:0]          req_valid = '0, req_wr = '0, rsp_ready = '0, err_clr = '0;
  logic [HN-1:0]          req_ready, rsp_valid;
  logic [HN*VN-1:0]       req_col_mask = '0, core_rvalid = '0;
  logic [HN*VN-1:0]       core_gbus_wen, core_gbus_ren;
  logic [HN*GA-1:0]       req_addr = '0, core_gbus_addr;
  logic [HN*GD-1:0]       req_wdata = '0, core_gbus_wdata, rsp_data;
  logic [HN*VN*GD-1:0]    core_rdata = '0;
  logic [HN*CWB-1:0]      rsp_col;
  logic [HN*3-1:0]        err_sticky;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  core_array_gbus_fabric #(
    .HNUM(HN), .VNUM(VN), .GBUS_DATA(GD), .GBUS_ADDR(GA), .CDATA_BIT(CB),
    .REQ_PIPE(1), .RSP_DEPTH(4), .SKEW(2)
  ) dut (
    .clk(clk), .rstn(rstn), .cfg_acc_num(cfg_acc_num), .core_acc_num(core_acc_num),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_col_mask(req_col_mask), .req_addr(req_addr), .req_wdata(req_wdata),
    .core_gbus_wen(core_gbus_wen), .core_gbus_ren(core_gbus_ren),
    .core_gbus_addr(core_gbus_addr), .core_gbus_wdata(core_gbus_wdata),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_col(rsp_col),
    .err_sticky(err_sticky), .err_clr(err_clr)
  );

  typedef struct {
    int         row;
    logic       wr;
    logic [3:0] mask;
    logic [11:0] addr;
    logic [63:0] data;
    logic [3:0] exp_wen;
    logic [3:0] exp_ren;
    logic [2:0] exp_err;
    int         exp_col;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input int row, input logic wr, input logic [3:0] mask,
                        input logic [11:0] addr, input logic [63:0] data,
                        input logic [3:0] exp_wen, input logic [3:0] exp_ren,
                        input logic [2:0] exp_err);
    logic [63:0] e;
    chk("req_ready_pre", 64'(req_ready[row]), 64'd1);
    req_valid[row]          = 1'b1;
    req_wr[row]             = wr;
    req_col_mask[row*4 +: 4] = mask;
    req_addr[row*GA +: GA]  = addr;
    req_wdata[row*GD +: GD] = data;
    step();
    req_valid = '0;
    @(negedge clk);
    e = 64'(exp_wen) << (row*4);
    chk("wen", 64'(core_gbus_wen), e);
    e = 64'(exp_ren) << (row*4);
    chk("ren", 64'(core_gbus_ren), e);
    chk("addr", 64'(core_gbus_addr[row*GA +: GA]), 64'(addr));
    if (wr) chk("wdata", core_gbus_wdata[row*GD +: GD], data);
    chk("err", 64'(err_sticky[row*3 +: 3]), 64'(exp_err));
    step();
    @(negedge clk);
    chk("wen_gone", 64'(core_gbus_wen), 64'd0);
    chk("ren_gone", 64'(core_gbus_ren), 64'd0);
    step();
  endtask

  task automatic read_return(input int row, input int col, input logic [63:0] data);
    core_rvalid[row*4 + col]               = 1'b1;
    core_rdata[(row*4 + col)*GD +: GD]     = data;
    step();
    core_rvalid = '0;
    @(negedge clk);
    chk("rsp_valid", 64'(rsp_valid[row]), 64'd1);
    chk("rsp_data", rsp_data[row*GD +: GD], data);
    chk("rsp_col", 64'(rsp_col[row*CWB +: CWB]), 64'(col));
    step();
    rsp_ready[row] = 1'b1;
    step();
    rsp_ready = '0;
    @(negedge clk);
    chk("rsp_drained", 64'(rsp_valid[row]), 64'd0);
    step();
  endtask

  task automatic clear_err(input int row);
    err_clr[row] = 1'b1;
    step();
    err_clr = '0;
    @(negedge clk);
    chk("err_cleared", 64'(err_sticky[row*3 +: 3]), 64'd0);
    step();
  endtask

  initial begin
    tbl[0] = '{0, 1'b1, 4'b1011, 12'h010, 64'hA5,   4'b1011, 4'b0000, 3'b000, 0};
    tbl[1] = '{1, 1'b0, 4'b0100, 12'h020, 64'hBEEF, 4'b0000, 4'b0100, 3'b000, 2};
    tbl[2] = '{2, 1'b1, 4'b0000, 12'h030, 64'h77,   4'b0000, 4'b0000, 3'b000, 0};
    tbl[3] = '{3, 1'b0, 4'b0110, 12'h040, 64'h0,    4'b0000, 4'b0000, 3'b001, 0};
    tbl[4] = '{2, 1'b0, 4'b0001, 12'h050, 64'h1234, 4'b0000, 4'b0001, 3'b000, 0};
    tbl[5] = '{3, 1'b1, 4'b1111, 12'hFFF, 64'hDEADBEEF_CAFEF00D, 4'b1111, 4'b0000, 3'b000, 0};
    tbl[6] = '{0, 1'b0, 4'b0000, 12'h060, 64'h0,    4'b0000, 4'b0000, 3'b001, 0};
    tbl[7] = '{1, 1'b0, 4'b1000, 12'h070, 64'h5A5A, 4'b0000, 4'b1000, 3'b000, 3};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_wen", 64'(core_gbus_wen), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_err", 64'(err_sticky), 64'd0);
    chk("rst_acc", 64'(|core_acc_num), 64'd0);
    step();
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_first_cycle", 64'(req_ready), 64'd0);
    step();
    chk("ready_after", 64'(req_ready), 64'hF);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      do_req(tbl[i].row, tbl[i].wr, tbl[i].mask, tbl[i].addr, tbl[i].data,
             tbl[i].exp_wen, tbl[i].exp_ren, tbl[i].exp_err);
      if (tbl[i].exp_ren != 4'b0000) read_return(tbl[i].row, tbl[i].exp_col, tbl[i].data);
      if (tbl[i].exp_err != 3'b000) clear_err(tbl[i].row);
      chk("rsp_idle", 64'(rsp_valid), 64'd0);
    end

    // Credit exhaustion and release on row 0
    for (int k = 0; k < 4; k++) begin
      do_req(0, 1'b0, 4'b0001, 12'h100, 64'h0, 4'b0000, 4'b0001, 3'b000);
    end
    chk("ready_full", 64'(req_ready[0]), 64'd0);
    for (int k = 0; k < 4; k++) begin
      core_rvalid[0] = 1'b1;
      core_rdata[0 +: GD] = 64'h100 + 64'(k);
      step();
    end
    core_rvalid = '0;
    @(negedge clk);
    chk("full_rsp_valid", 64'(rsp_valid[0]), 64'd1);
    chk("ready_still_full", 64'(req_ready[0]), 64'd0);
    step();
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("ready_no_bypass", 64'(req_ready[0]), 64'd0);
    chk("fifo_data0", rsp_data[0 +: GD], 64'h100);
    step();
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("fifo_data", rsp_data[0 +: GD], 64'h100 + 64'(k));
      if (k == 1) chk("ready_after_pop", 64'(req_ready[0]), 64'd1);
      step();
    end
    rsp_ready = '0;
    @(negedge clk);
    chk("fifo_empty", 64'(rsp_valid[0]), 64'd0);
    step();

    // Multi-rvalid, unexpected rvalid, set-wins-over-clear on row 2
    do_req(2, 1'b0, 4'b0010, 12'h200, 64'h0, 4'b0000, 4'b0010, 3'b000);
    core_rvalid[2*4 + 1] = 1'b1;
    core_rvalid[2*4 + 3] = 1'b1;
    core_rdata[(2*4 + 1)*GD +: GD] = 64'h1111;
    core_rdata[(2*4 + 3)*GD +: GD] = 64'h3333;
    step();
    core_rvalid = '0;
    @(negedge clk);
    chk("multi_col", 64'(rsp_col[2*CWB +: CWB]), 64'd1);
    chk("multi_data", rsp_data[2*GD +: GD], 64'h1111);
    chk("multi_err", 64'(err_sticky[2*3 +: 3]), 64'b010);
    step();
    rsp_ready[2] = 1'b1;
    step();
    rsp_ready = '0;
    core_rvalid[2*4] = 1'b1;
    step();
    core_rvalid = '0;
    @(negedge clk);
    chk("unexp_err", 64'(err_sticky[2*3 +: 3]), 64'b110);
    chk("unexp_no_push", 64'(rsp_valid[2]), 64'd0);
    step();
    core_rvalid[2*4 + 2] = 1'b1;
    err_clr[2] = 1'b1;
    step();
    core_rvalid = '0;
    err_clr = '0;
    @(negedge clk);
    chk("set_wins", 64'(err_sticky[2*3 +: 3]), 64'b100);
    step();
    clear_err(2);

    // acc_num skew chain, two stages per hop
    cfg_acc_num[7:0] = 8'd7;
    for (int k = 1; k <= 8; k++) begin
      step();
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("skew_c%0d_j%0d", k, j), 64'(core_acc_num[j*CB +: CB]),
            (k >= 2*(j+1)) ? 64'd7 : 64'd0);
      end
    end
    chk("skew_row1", 64'(core_acc_num[4*CB +: CB]), 64'd0);
    step();

    // Reset in the middle of traffic
    do_req(1, 1'b0, 4'b0001, 12'h300, 64'h0, 4'b0000, 4'b0001, 3'b000);
    core_rvalid[4] = 1'b1;
    core_rdata[4*GD +: GD] = 64'h9999;
    step();
    core_rvalid = '0;
    do_req(3, 1'b0, 4'b1100, 12'h310, 64'h0, 4'b0000, 4'b0000, 3'b001);
    req_valid[0] = 1'b1;
    req_wr[0] = 1'b1;
    req_col_mask[3:0] = 4'b1011;
    step();
    req_valid = '0;
    chk("pre_rst_wen", 64'(core_gbus_wen), 64'hB);
    chk("pre_rst_rsp", 64'(rsp_valid), 64'h2);
    rstn = 1'b0;
    #1;
    chk("mid_rst_wen", 64'(core_gbus_wen), 64'd0);
    chk("mid_rst_ren", 64'(core_gbus_ren), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_rsp", 64'(rsp_valid), 64'd0);
    chk("mid_rst_rdata", 64'(|rsp_data), 64'd0);
    chk("mid_rst_err", 64'(err_sticky), 64'd0);
    chk("mid_rst_acc", 64'(|core_acc_num), 64'd0);
    chk("mid_rst_addr", 64'(|core_gbus_addr), 64'd0);
    step();
    step();
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready0", 64'(req_ready), 64'd0);
    step();
    chk("post_rst_ready1", 64'(req_ready), 64'hF);
    chk("post_rst_fifo", 64'(rsp_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
